// File: rtl/hsp_writer.sv
// hsp_writer: queues 64-bit HSP records, packs eight per 512-bit line and writes each line to DDR.
// Optional feature macro HSP_DEDUP_EN: drop a hit identical to the last record pushed.
module hsp_writer #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned LINE_STRIDE = 512,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hit_valid,
  input  logic [31:0]  locationStart,
  input  logic [31:0]  locationEnd,
  input  logic         flush,
  output logic         ddr_wr,
  output logic [31:0]  ddr_wr_addr,
  output logic [511:0] ddr_wr_data,
  input  logic         ddr_wr_done,
  output logic         flush_done,
  output logic         overflow,
  output logic         busy,
  output logic [31:0]  recordCount
);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] EMPTY = {(AW+1){1'b0}};

  typedef enum logic [1:0] {COLLECT = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2} state_t;
  state_t state, nextState;

  logic [63:0]   fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   fifoCount, countNext;
  logic [2:0]    slotCnt, slotNext;
  logic [25:0]   lineCnt;
  logic [511:0]  lineReg, lineNext;
  logic          flushPend, flushPendNext;
  logic [63:0]   hitRec;
  logic          hitAccept, hitDrop, doPush, doPop;
  logic          doneWrite, flushLineDone, flushEmpty, issueNext, busyNext;
  logic [31:0]   issueAddr;

  assign hitRec = {locationStart, locationEnd};

`ifdef HSP_DEDUP_EN
  logic        lastValid;
  logic [63:0] lastRec;

  assign hitAccept = hit_valid && !(lastValid && (lastRec == hitRec));

  // Remember the most recently pushed record for duplicate suppression
  always_ff @(posedge clk) begin
    if (rst) begin
      lastValid <= 1'b0;
      lastRec   <= 64'd0;
    end else if (doPush) begin
      lastValid <= 1'b1;
      lastRec   <= hitRec;
    end
  end
`else
  assign hitAccept = hit_valid;
`endif

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= nextState;
    end
  end

  // Sequencer next-state: a line goes out when slot 7 fills or a pending flush finds the FIFO drained
  always_comb begin
    nextState = state;
    case (state)
      COLLECT: begin
        if (fifoCount != EMPTY) begin
          if (slotCnt == 3'd7) nextState = ISSUE;
          else                 nextState = COLLECT;
        end else if (flushPend && (slotCnt != 3'd0)) begin
          nextState = ISSUE;
        end else begin
          nextState = COLLECT;
        end
      end
      ISSUE: nextState = WAIT_DONE;
      WAIT_DONE: begin
        if (ddr_wr_done) nextState = COLLECT;
        else             nextState = WAIT_DONE;
      end
      default: nextState = COLLECT;
    endcase
  end

  // Sequencer outputs: FIFO handshake, line packing and flush bookkeeping
  always_comb begin
    doPop      = 1'b0;
    doneWrite  = 1'b0;
    flushEmpty = 1'b0;
    case (state)
      COLLECT: begin
        doPop      = (fifoCount != EMPTY);
        flushEmpty = (fifoCount == EMPTY) && flushPend && (slotCnt == 3'd0);
      end
      WAIT_DONE: doneWrite = ddr_wr_done;
      default:   doPop = 1'b0;
    endcase

    doPush  = hitAccept && (fifoCount != DEPTH);
    hitDrop = hitAccept && (fifoCount == DEPTH);
    // A full line wraps slotCnt to 0, so a nonzero count at completion marks the flushed partial line
    flushLineDone = doneWrite && flushPend && (slotCnt != 3'd0);

    if (doPush && !doPop)      countNext = fifoCount + 1'b1;
    else if (!doPush && doPop) countNext = fifoCount - 1'b1;
    else                       countNext = fifoCount;

    lineNext = lineReg;
    slotNext = slotCnt;
    if (doneWrite) begin
      lineNext = 512'd0;
      slotNext = 3'd0;
    end else if (doPop) begin
      lineNext[{slotCnt, 6'd0} +: 64] = fifoMem[rdPtr];
      slotNext = slotCnt + 3'd1;
    end else begin
      slotNext = slotCnt;
    end

    if (flushPend) flushPendNext = !(flushEmpty || flushLineDone);
    else           flushPendNext = flush;

    issueNext = (state == COLLECT) && (nextState == ISSUE);
    issueAddr = BASE_ADDR + ({6'd0, lineCnt} * 32'(LINE_STRIDE));
    busyNext  = (nextState != COLLECT) || (countNext != EMPTY) || flushPendNext || (slotNext != 3'd0);
  end

  // Record storage; occupancy is tracked by the pointers, so contents need no reset
  always_ff @(posedge clk) begin
    if (doPush) fifoMem[wrPtr] <= hitRec;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr       <= {AW{1'b0}};
      rdPtr       <= {AW{1'b0}};
      fifoCount   <= EMPTY;
      slotCnt     <= 3'd0;
      lineCnt     <= 26'd0;
      lineReg     <= 512'd0;
      flushPend   <= 1'b0;
      ddr_wr      <= 1'b0;
      ddr_wr_addr <= 32'd0;
      ddr_wr_data <= 512'd0;
      flush_done  <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      recordCount <= 32'd0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) begin
        rdPtr       <= rdPtr + 1'b1;
        recordCount <= recordCount + 32'd1;
      end
      fifoCount  <= countNext;
      slotCnt    <= slotNext;
      lineReg    <= lineNext;
      flushPend  <= flushPendNext;
      if (doneWrite) lineCnt <= lineCnt + 26'd1;
      if (hitDrop)   overflow <= 1'b1;
      ddr_wr     <= issueNext;
      if (issueNext) begin
        ddr_wr_addr <= issueAddr;
        ddr_wr_data <= lineNext;
      end
      flush_done <= flushEmpty || flushLineDone;
      busy       <= busyNext;
    end
  end
endmodule
